leitor_display_c2: RTL and testbench



---
 rtl/leitor_display_c2_pkg.sv | 19 +
 rtl/leitor_display_c2_if.sv | 15 +
 rtl/leitor_display_c2_decod_seg7.sv | 25 ++
 rtl/leitor_display_c2.sv | 168 ++++++++++++++++
 tb/tb_leitor_display_c2.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/leitor_display_c2_pkg.sv
// rtl/leitor_display_c2_pkg.sv - segment constants and FSM encoding shared with the display drivers
package leitor_display_c2_pkg;

  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low {g,f,e,d,c,b,a} patterns, indexed by digit value
  localparam logic [6:0] SEG_DIG [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    COLETA   = 2'd0,
    CONVERTE = 2'd1,
    EMITE    = 2'd2
  } estado_t;

endpackage

// File: rtl/leitor_display_c2_if.sv
// rtl/leitor_display_c2_if.sv - multiplexed display bus in, decoded value out
interface leitor_display_c2_if #(
  parameter int NDIG = 2,
  parameter int W    = 8
);
  logic [NDIG:0] an;
  logic [6:0]    seg;
  logic [W-1:0]  valor;
  logic          neg;
  logic          valid;
  logic          erro;

  modport master (output an, seg, input valor, neg, valid, erro);
  modport slave  (input an, seg, output valor, neg, valid, erro);
endinterface

// File: rtl/leitor_display_c2_decod_seg7.sv
// rtl/leitor_display_c2_decod_seg7.sv - seven-segment pattern to digit/blank/minus classifier
module decod_seg7
  import leitor_display_c2_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digito,
  output logic       eh_branco,
  output logic       eh_menos,
  output logic       invalido
);

  always_comb begin
    digito    = 4'd0;
    eh_branco = (seg == SEG_BLANK);
    eh_menos  = (seg == SEG_MINUS);
    invalido  = !(eh_branco || eh_menos);
    for (int i = 0; i < 10; i++) begin
      if (seg == SEG_DIG[i]) begin
        digito   = 4'(i);
        invalido = 1'b0;
      end
    end
  end

endmodule

// File: rtl/leitor_display_c2.sv
// rtl/leitor_display_c2.sv - display bus reader: stability filter, frame FSM, BCD to two's complement
// Optional: LEITOR_DEDUP_EN suppresses valid when the emitted triple repeats the previous one.
module leitor_display_c2
  import leitor_display_c2_pkg::*;
#(
  parameter int NDIG   = 2,
  parameter int STABLE = 4,
  parameter int W      = 8
) (
  input  logic clk,
  input  logic rst,
  leitor_display_c2_if.slave bus
);

  localparam int CW = $clog2(STABLE + 1);
  localparam int PW = $clog2(NDIG + 1);
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_TOP   = CW'(STABLE);
  localparam logic [NDIG:0] MASK_FULL = '1;

  estado_t        estado, prox;
  logic [NDIG:0]  an_q;
  logic [6:0]     seg_q;
  logic [CW-1:0]  cnt;
  logic [NDIG:0]  mascara;
  logic [3:0]     dig [NDIG];
  logic           neg_quadro;
  logic           erro_quadro;
  logic [W-1:0]   acc;
  logic [DW-1:0]  idx;
  logic [W-1:0]   valor_r;
  logic           neg_r, valid_r, erro_r;
`ifdef LEITOR_DEDUP_EN
  logic           primeiro;
`endif

  logic           um_quente, estavel, captura, ilegal, emite;
  logic [PW-1:0]  pos;
  logic [3:0]     d_digito;
  logic           d_branco, d_menos, d_inval;
  logic [NDIG:0]  mascara_nova;
  logic [W-1:0]   e_valor;
  logic           e_neg, e_erro;

  decod_seg7 u_decod (
    .seg       (bus.seg),
    .digito    (d_digito),
    .eh_branco (d_branco),
    .eh_menos  (d_menos),
    .invalido  (d_inval)
  );

  always_comb begin
    um_quente = $onehot(~bus.an);
    pos = '0;
    for (int i = 0; i <= NDIG; i++) begin
      if (!bus.an[i]) pos = PW'(i);
    end
    estavel = um_quente && (bus.an == an_q) && (bus.seg == seg_q);
    captura = (estado == COLETA) && estavel && (cnt == CNT_TOP - CW'(1));

    // A minus is only legal in the sign position; digits accept 0..9 or blank
    ilegal = 1'b0;
    if (pos == PW'(NDIG)) ilegal = !(d_menos || d_branco);
    else                  ilegal = d_inval || d_menos;

    mascara_nova = mascara;
    if (captura) mascara_nova[pos] = 1'b1;

    if (erro_quadro) begin
      e_valor = '0;
      e_neg   = 1'b0;
      e_erro  = 1'b1;
    end else begin
      e_valor = neg_quadro ? -acc : acc;
      e_neg   = neg_quadro && (acc != '0);
      e_erro  = 1'b0;
    end

`ifdef LEITOR_DEDUP_EN
    emite = primeiro || ({e_valor, e_neg, e_erro} != {valor_r, neg_r, erro_r});
`else
    emite = 1'b1;
`endif
  end

  always_comb begin
    prox = estado;
    case (estado)
      COLETA:   if (mascara_nova == MASK_FULL) prox = CONVERTE;
      CONVERTE: if (idx == '0) prox = EMITE;
      EMITE:    prox = COLETA;
      default:  prox = COLETA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= COLETA;
    else     estado <= prox;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      cnt         <= '0;
      mascara     <= '0;
      for (int i = 0; i < NDIG; i++) dig[i] <= 4'd0;
      neg_quadro  <= 1'b0;
      erro_quadro <= 1'b0;
      acc         <= '0;
      idx         <= '0;
      valor_r     <= '0;
      neg_r       <= 1'b0;
      valid_r     <= 1'b0;
      erro_r      <= 1'b0;
`ifdef LEITOR_DEDUP_EN
      primeiro    <= 1'b1;
`endif
    end else begin
      an_q    <= bus.an;
      seg_q   <= bus.seg;
      valid_r <= 1'b0;

      if (estado != COLETA || !estavel) cnt <= '0;
      else if (cnt != CNT_TOP)           cnt <= cnt + CW'(1);

      case (estado)
        COLETA: begin
          if (captura) begin
            mascara <= mascara_nova;
            if (pos == PW'(NDIG)) neg_quadro <= d_menos;
            else dig[pos[DW-1:0]] <= (ilegal || d_branco) ? 4'd0 : d_digito;
            if (ilegal) erro_quadro <= 1'b1;
          end
          idx <= DW'(NDIG - 1);
          acc <= '0;
        end
        CONVERTE: begin
          // Most significant digit first: acc = acc*10 + d
          acc <= acc * W'(10) + W'(dig[idx]);
          idx <= idx - DW'(1);
        end
        EMITE: begin
          if (emite) begin
            valor_r <= e_valor;
            neg_r   <= e_neg;
            erro_r  <= e_erro;
            valid_r <= 1'b1;
`ifdef LEITOR_DEDUP_EN
            primeiro <= 1'b0;
`endif
          end
          mascara     <= '0;
          erro_quadro <= 1'b0;
          acc         <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.valor = valor_r;
  assign bus.neg   = neg_r;
  assign bus.valid = valid_r;
  assign bus.erro  = erro_r;

endmodule

// File: tb/tb_leitor_display_c2.sv
// tb/tb_leitor_display_c2.sv - bench for leitor_display_c2: frame model, scoreboard and literal checks
module tb_leitor_display_c2;

  localparam int NDIG   = 2;
  localparam int STABLE = 4;
  localparam int W      = 8;
`ifdef LEITOR_DEDUP_EN
  localparam int NREP = 2;
`else
  localparam int NREP = 4;
`endif

  localparam logic [6:0] MENOS  = 7'b0111111;
  localparam logic [6:0] BRANCO = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  leitor_display_c2_if #(.NDIG(NDIG), .W(W)) bus();

  leitor_display_c2 #(.NDIG(NDIG), .STABLE(STABLE), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] pd [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    int         ciclo;
    logic [7:0] valor;
    logic       neg;
    logic       erro;
  } esp_t;

  esp_t       fila[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         nvalid = 0;
  int         nv0;
  logic [6:0] quadro [NDIG+1];
  logic [NDIG:0] mask_m;
  logic [7:0] ult_valor, vis_valor;
  logic       ult_neg, ult_erro, primeiro_m, vis_neg, vis_erro;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] req);
    checks++;
    if (atual !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, req);
    end
  endtask

  function automatic int dec(input logic [6:0] p);
    if (p == BRANCO) return 10;
    if (p == MENOS)  return 11;
    for (int i = 0; i < 10; i++) if (p == pd[i]) return i;
    return -1;
  endfunction

  // Value a completed frame must produce, from the display rules alone
  task automatic fecha_quadro(input int ciclo);
    int mag, d;
    logic e, n;
    logic [7:0] v;
    esp_t x;
    e = 1'b0; n = 1'b0; mag = 0;
    d = dec(quadro[NDIG]);
    if (d == 11) n = 1'b1;
    else if (d != 10) e = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = dec(quadro[i]);
      if (d >= 0 && d <= 9) mag = mag * 10 + d;
      else begin
        mag = mag * 10;
        if (d != 10) e = 1'b1;
      end
    end
    if (e) begin
      v = 8'd0; n = 1'b0;
    end else begin
      v = n ? 8'((256 - mag) % 256) : 8'(mag);
      n = n && (mag != 0);
    end
`ifdef LEITOR_DEDUP_EN
    if (!primeiro_m && v == ult_valor && n == ult_neg && e == ult_erro) return;
`endif
    x.ciclo = ciclo; x.valor = v; x.neg = n; x.erro = e;
    fila.push_back(x);
    ult_valor = v; ult_neg = n; ult_erro = e; primeiro_m = 1'b0;
  endtask

  // Called at a negedge; holds position p with pattern pat for h cycles
  task automatic posicao(input int p, input logic [6:0] pat, input int h);
    int c;
    c = cyc;
    bus.an  = ~(3'b001 << p);
    bus.seg = pat;
    if (h >= STABLE + 1) begin
      quadro[p] = pat;
      mask_m[p] = 1'b1;
      if (&mask_m) begin
        mask_m = '0;
        fecha_quadro(c + 1 + STABLE + NDIG + 1);
      end
    end
    repeat (h) @(negedge clk);
  endtask

  task automatic ocioso(input int n);
    bus.an  = '1;
    bus.seg = BRANCO;
    repeat (n) @(negedge clk);
  endtask

  task automatic quadro3(input logic [6:0] s, input logic [6:0] t, input logic [6:0] u);
    posicao(2, s, 6);
    posicao(1, t, 6);
    posicao(0, u, 6);
    ocioso(10);
  endtask

  task automatic lit(input string nome, input logic [7:0] v, input logic n, input logic e);
    chk({nome, "_valor"}, bus.valor, v);
    chk({nome, "_neg"}, bus.neg, n);
    chk({nome, "_erro"}, bus.erro, e);
  endtask

  // Scoreboard: every valid must match the oldest expected frame, on its cycle
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        vis_valor = 8'd0; vis_neg = 1'b0; vis_erro = 1'b0;
        continue;
      end
      if (bus.valid) begin
        nvalid++;
        if (fila.size() == 0) chk("valid_inesperado", bus.valid, 0);
        else begin
          chk("latencia", cyc, fila[0].ciclo);
          chk("valor", bus.valor, fila[0].valor);
          chk("neg", bus.neg, fila[0].neg);
          chk("erro", bus.erro, fila[0].erro);
          vis_valor = fila[0].valor; vis_neg = fila[0].neg; vis_erro = fila[0].erro;
          void'(fila.pop_front());
        end
      end else begin
        if (fila.size() != 0 && cyc > fila[0].ciclo) begin
          chk("valid_ausente", bus.valid, 1);
          void'(fila.pop_front());
        end
        chk("hold", {bus.valor, bus.neg, bus.erro}, {vis_valor, vis_neg, vis_erro});
      end
    end
  end

  initial begin
    bus.an = '1; bus.seg = BRANCO;
    mask_m = '0; primeiro_m = 1'b1;
    ult_valor = 8'd0; ult_neg = 1'b0; ult_erro = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset", 8'h00, 1'b0, 1'b0);
    chk("reset_valid", bus.valid, 0);
    rst = 1'b0;
    ocioso(4);

    quadro3(MENOS, pd[4], pd[2]);
    lit("m42", 8'hD6, 1'b1, 1'b0);

    quadro3(BRANCO, pd[9], pd[9]);
    lit("p99", 8'h63, 1'b0, 1'b0);

    quadro3(BRANCO, pd[3], 7'b1010101);
    lit("ilegal", 8'h00, 1'b0, 1'b1);
    quadro3(MENOS, BRANCO, pd[5]);
    lit("m5", 8'hFB, 1'b1, 1'b0);

    nv0 = nvalid;
    posicao(2, BRANCO, 6);
    posicao(1, pd[3], 6);
    posicao(0, pd[1], 3);
    posicao(0, pd[8], 6);
    ocioso(10);
    chk("glitch_nvalid", nvalid - nv0, 1);
    lit("glitch", 8'h26, 1'b0, 1'b0);

    nv0 = nvalid;
    posicao(2, MENOS, 6);
    posicao(1, pd[0], 6);
    posicao(0, pd[7], 5);
    rst = 1'b1;
    bus.an = '1; bus.seg = BRANCO;
    fila.delete();
    mask_m = '0; primeiro_m = 1'b1;
    ult_valor = 8'd0; ult_neg = 1'b0; ult_erro = 1'b0;
    #1;
    lit("abort", 8'h00, 1'b0, 1'b0);
    chk("abort_valid", bus.valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ocioso(8);
    chk("abort_nvalid", nvalid - nv0, 0);
    quadro3(MENOS, pd[0], pd[7]);
    lit("m07", 8'hF9, 1'b1, 1'b0);

    nv0 = nvalid;
    repeat (3) quadro3(BRANCO, pd[1], pd[2]);
    quadro3(BRANCO, pd[1], pd[3]);
    chk("rep_nvalid", nvalid - nv0, NREP);
    lit("p13", 8'h0D, 1'b0, 1'b0);

    quadro3(MENOS, BRANCO, pd[0]);
    lit("neg_zero", 8'h00, 1'b0, 1'b0);

    quadro3(BRANCO, MENOS, pd[1]);
    lit("menos_digito", 8'h00, 1'b0, 1'b1);

    ocioso(10);
    chk("fila_vazia", fila.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
